// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode: register file, load-use hazard detect, ID/EX register
module decode_stage #(
  parameter logic [4:0] OPC_LOAD = 5'b01101,
  parameter logic [4:0] OPC_NOP  = 5'b11111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic [15:0] npc_in,
  input  logic        instr_valid,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_index,
  input  logic [15:0] wb_data,
  output logic        stall_out,
  output logic        valid_out,
  output logic [4:0]  control_out,
  output logic [4:0]  dest_index_out,
  output logic [15:0] reg1_data,
  output logic [15:0] reg2_data,
  output logic [15:0] npc_out,
  output logic [6:0]  immediate
);

  logic [15:0] regs [32];
  logic [4:0]  op, dest, src1, src2;
  logic [6:0]  imm;
  logic [15:0] rd1, rd2;
  logic        hazard;
  logic        unused_instr_bits;

  assign op   = instr_in[31:27];
  assign dest = instr_in[26:22];
  assign src1 = instr_in[21:17];
  assign src2 = instr_in[16:12];
  assign imm  = instr_in[6:0];
  assign unused_instr_bits = ^instr_in[11:7];

  // Reads see this cycle's writeback so a write and a dependent read can share a cycle.
  always_comb begin
    rd1 = 16'd0;
    rd2 = 16'd0;
    if (src1 != 5'd0) begin
      rd1 = (wb_en && wb_index == src1) ? wb_data : regs[src1];
    end
    if (src2 != 5'd0) begin
      rd2 = (wb_en && wb_index == src2) ? wb_data : regs[src2];
    end
  end

  assign hazard = valid_out && (control_out == OPC_LOAD) && (dest_index_out != 5'd0)
                  && instr_valid && ((src1 == dest_index_out) || (src2 == dest_index_out));

  // A flush kills the instruction anyway, so there is nothing to hold fetch for.
  assign stall_out = hazard && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 16'd0;
      end
    end else if (wb_en && wb_index != 5'd0) begin
      regs[wb_index] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out      <= 1'b0;
      control_out    <= OPC_NOP;
      dest_index_out <= 5'd0;
      reg1_data      <= 16'd0;
      reg2_data      <= 16'd0;
      npc_out        <= 16'd0;
      immediate      <= 7'd0;
    end else if (flush || hazard || !instr_valid) begin
      valid_out      <= 1'b0;
      control_out    <= OPC_NOP;
      dest_index_out <= 5'd0;
      reg1_data      <= 16'd0;
      reg2_data      <= 16'd0;
      npc_out        <= 16'd0;
      immediate      <= 7'd0;
    end else begin
      valid_out      <= 1'b1;
      control_out    <= op;
      dest_index_out <= dest;
      reg1_data      <= rd1;
      reg2_data      <= rd2;
      npc_out        <= npc_in;
      immediate      <= imm;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  localparam logic [4:0] OPC_LOAD = 5'b01101;
  localparam logic [4:0] OPC_NOP  = 5'b11111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_in = 32'd0;
  logic [15:0] npc_in = 16'd0;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_index = 5'd0;
  logic [15:0] wb_data = 16'd0;
  logic        stall_out, valid_out;
  logic [4:0]  control_out, dest_index_out;
  logic [15:0] reg1_data, reg2_data, npc_out;
  logic [6:0]  immediate;

  int passed = 0;
  int total  = 0;

  decode_stage #(.OPC_LOAD(OPC_LOAD), .OPC_NOP(OPC_NOP)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .npc_in(npc_in),
    .instr_valid(instr_valid), .flush(flush), .wb_en(wb_en), .wb_index(wb_index),
    .wb_data(wb_data), .stall_out(stall_out), .valid_out(valid_out),
    .control_out(control_out), .dest_index_out(dest_index_out), .reg1_data(reg1_data),
    .reg2_data(reg2_data), .npc_out(npc_out), .immediate(immediate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: architectural register contents plus the instruction expected in ID/EX.
  logic [15:0] m_rf [32];
  logic        e_valid;
  logic [4:0]  e_ctrl, e_dest;
  logic [15:0] e_r1, e_r2, e_npc;
  logic [6:0]  e_imm;

  function automatic logic [15:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 16'd0;
    if (wb_en && wb_index == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic m_stall();
    logic [4:0] s1, s2;
    s1 = instr_in[21:17];
    s2 = instr_in[16:12];
    if (flush || !instr_valid || !e_valid || e_ctrl != OPC_LOAD || e_dest == 5'd0) return 1'b0;
    return (s1 == e_dest) || (s2 == e_dest);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_rf[i] <= 16'd0;
      e_valid <= 1'b0; e_ctrl <= OPC_NOP; e_dest <= 5'd0;
      e_r1 <= 16'd0; e_r2 <= 16'd0; e_npc <= 16'd0; e_imm <= 7'd0;
    end else begin
      if (flush || m_stall() || !instr_valid || (e_valid && e_ctrl == OPC_LOAD && e_dest != 5'd0
          && (instr_in[21:17] == e_dest || instr_in[16:12] == e_dest))) begin
        e_valid <= 1'b0; e_ctrl <= OPC_NOP; e_dest <= 5'd0;
        e_r1 <= 16'd0; e_r2 <= 16'd0; e_npc <= 16'd0; e_imm <= 7'd0;
      end else begin
        e_valid <= 1'b1; e_ctrl <= instr_in[31:27]; e_dest <= instr_in[26:22];
        e_r1 <= m_read(instr_in[21:17]); e_r2 <= m_read(instr_in[16:12]);
        e_npc <= npc_in; e_imm <= instr_in[6:0];
      end
      if (wb_en && wb_index != 5'd0) m_rf[wb_index] <= wb_data;
    end
  end

  always @(negedge clk) begin
    chk("stall_out", {31'd0, stall_out}, {31'd0, m_stall()});
    chk("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
    chk("control_out", {27'd0, control_out}, {27'd0, e_ctrl});
    chk("dest_index_out", {27'd0, dest_index_out}, {27'd0, e_dest});
    chk("reg1_data", {16'd0, reg1_data}, {16'd0, e_r1});
    chk("reg2_data", {16'd0, reg2_data}, {16'd0, e_r2});
    chk("npc_out", {16'd0, npc_out}, {16'd0, e_npc});
    chk("immediate", {25'd0, immediate}, {25'd0, e_imm});
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [6:0] imm);
    return {op, d, s1, s2, 5'd0, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [15:0] npc);
    instr_in = ins; npc_in = npc; instr_valid = 1'b1;
  endtask

  initial begin
    tick(); tick();
    chk("reset_valid", {31'd0, valid_out}, 32'd0);
    chk("reset_ctrl", {27'd0, control_out}, {27'd0, OPC_NOP});
    rst_n = 1'b1;

    wb_en = 1'b1; wb_index = 5'd1; wb_data = 16'd10; tick();
    wb_index = 5'd2; wb_data = 16'd3; tick();
    wb_en = 1'b0;
    issue(mk(5'b00001, 5'd2, 5'd1, 5'd2, 7'h11), 16'h0040); tick();
    chk("sub_ctrl", {27'd0, control_out}, 32'd1);
    chk("sub_dest", {27'd0, dest_index_out}, 32'd2);
    chk("sub_r1", {16'd0, reg1_data}, 32'd10);
    chk("sub_r2", {16'd0, reg2_data}, 32'd3);
    chk("sub_valid", {31'd0, valid_out}, 32'd1);

    wb_en = 1'b1; wb_index = 5'd5; wb_data = 16'h1234;
    issue(mk(5'b00010, 5'd6, 5'd5, 5'd0, 7'h01), 16'h0041); tick();
    chk("bypass_r1", {16'd0, reg1_data}, 32'h1234);
    wb_en = 1'b0;
    issue(mk(5'b00010, 5'd6, 5'd0, 5'd5, 7'h02), 16'h0042); tick();
    chk("r5_held", {16'd0, reg2_data}, 32'h1234);

    issue(mk(OPC_LOAD, 5'd4, 5'd1, 5'd0, 7'h03), 16'h0043); tick();
    issue(mk(5'b00000, 5'd7, 5'd4, 5'd0, 7'h04), 16'h0044); #1;
    chk("lu_stall", {31'd0, stall_out}, 32'd1);
    tick();
    chk("lu_bubble", {31'd0, valid_out}, 32'd0);
    #1 chk("lu_stall_end", {31'd0, stall_out}, 32'd0);
    tick();
    chk("lu_add_valid", {31'd0, valid_out}, 32'd1);
    chk("lu_add_npc", {16'd0, npc_out}, 32'h0044);

    issue(mk(OPC_LOAD, 5'd4, 5'd2, 5'd0, 7'h05), 16'h0045); tick();
    issue(mk(5'b00000, 5'd7, 5'd0, 5'd4, 7'h06), 16'h0046); flush = 1'b1; #1;
    chk("flush_stall", {31'd0, stall_out}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_bubble", {31'd0, valid_out}, 32'd0);

    wb_en = 1'b1; wb_index = 5'd0; wb_data = 16'hFFFF;
    issue(mk(5'b00011, 5'd8, 5'd0, 5'd0, 7'h07), 16'h0047); tick();
    wb_en = 1'b0;
    issue(mk(5'b00011, 5'd8, 5'd0, 5'd0, 7'h08), 16'h0048); tick();
    chk("r0_read", {16'd0, reg1_data}, 32'd0);
    issue(mk(OPC_LOAD, 5'd0, 5'd1, 5'd0, 7'h09), 16'h0049); tick();
    issue(mk(5'b00000, 5'd9, 5'd0, 5'd0, 7'h0a), 16'h004a); #1;
    chk("load_r0_nostall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("load_r0_issue", {31'd0, valid_out}, 32'd1);

    for (int i = 0; i < 60; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 2) == 0) ? OPC_LOAD : 5'($urandom_range(0, 31));
      issue(mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 7'($urandom)), 16'($urandom));
      instr_valid = ($urandom_range(0, 4) != 0);
      flush = ($urandom_range(0, 7) == 0);
      wb_en = ($urandom_range(0, 1) == 1);
      wb_index = 5'($urandom_range(0, 7));
      wb_data = 16'($urandom);
      tick();
    end
    flush = 1'b0; wb_en = 1'b0;

    issue(mk(5'b00001, 5'd3, 5'd1, 5'd2, 7'h0b), 16'h0050); tick();
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("mid_rst_ctrl", {27'd0, control_out}, {27'd0, OPC_NOP});
    chk("mid_rst_r1", {16'd0, reg1_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int r = 1; r < 32; r++) begin
      issue(mk(5'b00001, 5'd3, 5'(r), 5'(r), 7'h0c), 16'h0060); tick();
      chk("post_rst_read", {16'd0, reg1_data}, 32'd0);
    end

    instr_valid = 1'b0; tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
